alu_share_arbiter: RTL and testbench

- Shares one ALU instance between two execute-side requesters, e.g. integer pipe (req0) and branch/address unit (req1).
- Arbitrates round-robin and registers the granted operands into the ALU.
- Waits on the ALU finish flag, then holds the result in a response register with a valid/ready handshake.
- Sits in the EX stage between requesters and the ALU; all ALU control is one-hot, driven from registers.

---
 rtl/alu_share_arbiter.sv | 172 +++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one multi-cycle ALU between two EX-stage requesters.
// Registers the granted operation into the ALU and returns its result via valid/ready.
module alu_share_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [OPW-1:0]  i_req0_op,
  input  logic [XLEN-1:0] i_req0_a,
  input  logic [XLEN-1:0] i_req0_b,
  input  logic [XLEN-1:0] i_req0_c,
  input  logic            i_req0_ce,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [OPW-1:0]  i_req1_op,
  input  logic [XLEN-1:0] i_req1_a,
  input  logic [XLEN-1:0] i_req1_b,
  input  logic [XLEN-1:0] i_req1_c,
  input  logic            i_req1_ce,
  output logic [9:0]      o_alu_sel,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [XLEN-1:0] o_alu_c,
  output logic            o_alu_ce,
  input  logic [XLEN-1:0] i_alu_y,
  input  logic            i_alu_finish,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_rsp_id,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_err,
  output logic            o_busy
);

  localparam int unsigned NumOps = 10;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [9:0]        sel_q, sel_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic              ce_q, ce_d;
  logic              illegal_q, illegal_d;
  logic              exec_id_q, exec_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              win, gnt0, gnt1;
  logic [OPW-1:0]    g_op;
  logic [9:0]        g_sel;

  // Reset gating keeps ready low while reset is asserted.
  assign win  = i_rst_n && ((state_q == StIdle) || ((state_q == StResp) && i_rsp_ready));
  assign gnt0 = win && i_req0_valid && (!i_req1_valid || !rr_q);
  assign gnt1 = win && i_req1_valid && (!i_req0_valid || rr_q);
  assign g_op = gnt1 ? i_req1_op : i_req0_op;

  always_comb begin
    g_sel = '0;
    for (int unsigned i = 0; i < NumOps; i++) begin
      g_sel[i] = (g_op == OPW'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    sel_d       = sel_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    ce_d        = ce_q;
    illegal_d   = illegal_q;
    exec_id_d   = exec_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: ;
      StExec: begin
        // Illegal ops never reach the ALU, so its finish flag is irrelevant.
        if (illegal_q) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = exec_id_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end else if (i_alu_finish) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = exec_id_q;
          rsp_data_d  = i_alu_y;
          rsp_err_d   = 1'b0;
          sel_d       = '0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (gnt0 || gnt1) begin
      a_d       = gnt1 ? i_req1_a : i_req0_a;
      b_d       = gnt1 ? i_req1_b : i_req0_b;
      c_d       = gnt1 ? i_req1_c : i_req0_c;
      ce_d      = (gnt1 ? i_req1_ce : i_req0_ce) & g_sel[0];
      sel_d     = g_sel;
      illegal_d = ~|g_sel;
      exec_id_d = gnt1;
      rr_d      = ~gnt1;
      state_d   = StExec;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      sel_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      ce_q        <= 1'b0;
      illegal_q   <= 1'b0;
      exec_id_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      ce_q        <= ce_d;
      illegal_q   <= illegal_d;
      exec_id_q   <= exec_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;
  assign o_alu_sel    = sel_q;
  assign o_alu_a      = a_q;
  assign o_alu_b      = b_q;
  assign o_alu_c      = c_q;
  assign o_alu_ce     = ce_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the far side.
module tb_alu_share_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;

  logic            clk, rst_n;
  logic            v0, v1, r0, r1, ce0, ce1;
  logic [OPW-1:0]  op0, op1;
  logic [XLEN-1:0] a0, b0, c0, a1, b1, c1;
  logic [9:0]      alu_sel;
  logic [XLEN-1:0] alu_a, alu_b, alu_c, alu_y;
  logic            alu_ce, alu_finish;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [XLEN-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_op(op0),
    .i_req0_a(a0), .i_req0_b(b0), .i_req0_c(c0), .i_req0_ce(ce0),
    .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_op(op1),
    .i_req1_a(a1), .i_req1_b(b1), .i_req1_c(c1), .i_req1_ce(ce1),
    .o_alu_sel(alu_sel), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_c(alu_c),
    .o_alu_ce(alu_ce), .i_alu_y(alu_y), .i_alu_finish(alu_finish),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model driven by the registered one-hot select.
  always_comb begin
    alu_y = '0;
    case (alu_sel)
      10'h001: alu_y = alu_a + alu_b + (alu_ce ? alu_c : '0);
      10'h002: alu_y = alu_a - alu_b;
      10'h004: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      10'h008: alu_y = {31'd0, alu_a < alu_b};
      10'h010: alu_y = alu_a ^ alu_b;
      10'h020: alu_y = alu_a | alu_b;
      10'h040: alu_y = alu_a & alu_b;
      10'h080: alu_y = alu_a << alu_b[4:0];
      10'h100: alu_y = alu_a >> alu_b[4:0];
      10'h200: alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_y = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    v0 = 0; v1 = 0; op0 = '0; op1 = '0; ce0 = 0; ce1 = 0;
    a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
    rsp_ready = 1'b1; alu_finish = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({alu_sel, alu_a, alu_ce, rsp_valid, rsp_id, rsp_data, rsp_err, busy, r0, r1} !== '0) begin
      errors++;
      $display("FAIL reset_state sel=%h a=%h valid=%b data=%h busy=%b (all required 0)",
               alu_sel, alu_a, rsp_valid, rsp_data, busy);
    end
    tick();
  endtask

  task automatic test_single_add();
    apply_reset();
    v0 = 1; op0 = 4'd0; a0 = 5; b0 = 7; c0 = 3; ce0 = 1;
    @(negedge clk);
    checks++;
    if ({r0, r1} !== 2'b10) begin
      errors++; $display("FAIL add_grant ready=%b required 10", {r0, r1});
    end
    tick();
    v0 = 0;
    @(negedge clk);
    checks++;
    if (alu_sel !== 10'h001 || alu_ce !== 1'b1 || alu_a !== 5 || busy !== 1'b1) begin
      errors++; $display("FAIL add_exec sel=%h ce=%b a=%h required 001 1 5", alu_sel, alu_ce, alu_a);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd15 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL add_rsp valid=%b data=%0d id=%b err=%b required 1 15 0 0",
               rsp_valid, rsp_data, rsp_id, rsp_err);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL add_idle valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_tie_fairness();
    logic exp_r0, exp_r1, exp_v, exp_id;
    logic [XLEN-1:0] exp_d;
    apply_reset();
    v0 = 1; op0 = 4'd0; a0 = 1; b0 = 2; c0 = 9; ce0 = 0;
    v1 = 1; op1 = 4'd1; a1 = 10; b1 = 3; ce1 = 1;
    for (int k = 0; k < 8; k++) begin
      exp_r0 = (k % 2 == 0) && ((k / 2) % 2 == 0);
      exp_r1 = (k % 2 == 0) && ((k / 2) % 2 == 1);
      exp_v  = (k % 2 == 0) && (k >= 2);
      exp_id = ((k / 2) % 2 == 0);
      exp_d  = exp_id ? 32'd7 : 32'd3;
      @(negedge clk);
      checks++;
      if ({r0, r1} !== {exp_r0, exp_r1}) begin
        errors++;
        $display("FAIL tie_ready k=%0d ready=%b required %b", k, {r0, r1}, {exp_r0, exp_r1});
      end
      checks++;
      if (rsp_valid !== exp_v || (exp_v && (rsp_id !== exp_id || rsp_data !== exp_d))) begin
        errors++;
        $display("FAIL tie_rsp k=%0d valid=%b id=%b data=%0d required %b %b %0d",
                 k, rsp_valid, rsp_id, rsp_data, exp_v, exp_id, exp_d);
      end
      tick();
    end
    v0 = 0; v1 = 0;
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    v0 = 1; op0 = 4'd0; a0 = 4; b0 = 4; ce0 = 0;
    tick();
    v0 = 0; v1 = 1; op1 = 4'd4; a1 = 32'hF0; b1 = 32'hFF; rsp_ready = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (r1 !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'd8 || rsp_id !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold k=%0d ready1=%b valid=%b data=%0d required 0 1 8",
                 k, r1, rsp_valid, rsp_data);
      end
      tick();
    end
    rsp_ready = 1;
    @(negedge clk);
    checks++;
    if (r1 !== 1'b1 || rsp_data !== 32'd8) begin
      errors++; $display("FAIL bp_release ready1=%b data=%0d required 1 8", r1, rsp_data);
    end
    tick();
    v1 = 0;
    @(negedge clk);
    checks++;
    if (alu_sel !== 10'h010 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_exec sel=%h valid=%b required 010 0", alu_sel, rsp_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0F || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL bp_rsp2 valid=%b data=%h id=%b required 1 0f 1", rsp_valid, rsp_data, rsp_id);
    end
    tick();
  endtask

  task automatic test_alu_stall();
    apply_reset();
    alu_finish = 0;
    v1 = 1; op1 = 4'd9; a1 = 32'h8000_0000; b1 = 32'd4;
    @(negedge clk);
    checks++;
    if ({r0, r1} !== 2'b01) begin
      errors++; $display("FAIL stall_grant ready=%b required 01", {r0, r1});
    end
    tick();
    v1 = 0; a1 = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) alu_finish = 1;
      @(negedge clk);
      checks++;
      if (alu_sel !== 10'h200 || alu_a !== 32'h8000_0000 || alu_b !== 32'd4 || rsp_valid !== 1'b0)
      begin
        errors++;
        $display("FAIL stall_hold k=%0d sel=%h a=%h b=%h valid=%b required 200 80000000 4 0",
                 k, alu_sel, alu_a, alu_b, rsp_valid);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hF800_0000 || rsp_id !== 1'b1 || alu_sel !== '0)
    begin
      errors++;
      $display("FAIL stall_rsp valid=%b data=%h id=%b sel=%h required 1 f8000000 1 000",
               rsp_valid, rsp_data, rsp_id, alu_sel);
    end
    tick();
  endtask

  task automatic test_illegal_op();
    apply_reset();
    alu_finish = 0;
    v0 = 1; op0 = 4'd12; a0 = 32'hDEAD; b0 = 32'hBEEF;
    @(negedge clk);
    checks++;
    if (r0 !== 1'b1) begin
      errors++; $display("FAIL ill_grant ready0=%b required 1", r0);
    end
    tick();
    v0 = 0;
    @(negedge clk);
    checks++;
    if (alu_sel !== '0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ill_exec sel=%h valid=%b busy=%b required 000 0 1", alu_sel, rsp_valid, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL ill_rsp valid=%b err=%b data=%h id=%b required 1 1 0 0",
               rsp_valid, rsp_err, rsp_data, rsp_id);
    end
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    alu_finish = 0;
    v0 = 1; op0 = 4'd0; a0 = 1; b0 = 1; ce0 = 1; c0 = 1;
    tick();
    v1 = 1; op1 = 4'd2; a1 = 5; b1 = 6;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || alu_sel !== 10'h001) begin
      errors++; $display("FAIL ar_exec busy=%b sel=%h required 1 001", busy, alu_sel);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({alu_sel, alu_a, alu_b, alu_c, alu_ce, rsp_valid, busy, r0, r1} !== '0) begin
      errors++;
      $display("FAIL ar_clear sel=%h a=%h ce=%b valid=%b busy=%b ready=%b required all 0",
               alu_sel, alu_a, alu_ce, rsp_valid, busy, {r0, r1});
    end
    tick();
    rst_n = 1; alu_finish = 1; a0 = 3; b0 = 3; ce0 = 0;
    @(negedge clk);
    checks++;
    if ({r0, r1} !== 2'b10 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_prio ready=%b valid=%b required 10 0", {r0, r1}, rsp_valid);
    end
    tick();
    v0 = 0; v1 = 0;
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd6 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL ar_rsp valid=%b data=%0d id=%b required 1 6 0", rsp_valid, rsp_data, rsp_id);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_tie_fairness();
    test_backpressure();
    test_alu_stall();
    test_illegal_op();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
